// File: rtl/alu_acc_if.sv
// alu_acc_if: control/operand/result bundle between cu/MBR and the accumulator stage
interface alu_acc_if #(
    parameter int DATA_W = 16
);
    logic [31:0]       control_signal;
    logic [DATA_W-1:0] data_from_mbr;
    logic [DATA_W-1:0] data_to_mbr_acc;
    logic [DATA_W-1:0] data_to_mbr_mr;
    logic [7:0]        flags;
    logic              busy;

    modport master (
        output control_signal, data_from_mbr,
        input  data_to_mbr_acc, data_to_mbr_mr, flags, busy
    );

    modport slave (
        input  control_signal, data_from_mbr,
        output data_to_mbr_acc, data_to_mbr_mr, flags, busy
    );
endinterface

// File: rtl/alu_acc.sv
// alu_acc: BR/ACC/MR datapath with single-cycle ALU ops and a 16-step shift-add multiply; ALU_SIGNED_MPY_EN selects a signed Booth multiply
module alu_acc #(
    parameter int DATA_W       = 16,
    parameter int CS_BR_LOAD   = 10,
    parameter int CS_ACC_CLR   = 11,
    parameter int CS_ALU_START = 12,
    parameter int CS_OP_LSB    = 13
) (
    input  logic      clk,
    input  logic      rst,
    alu_acc_if.slave  bus
);
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] br_q, br_d, acc_q, acc_d, mr_q, mr_d, m_q, m_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic              busy_q, busy_d, done_q, done_d;
`ifdef ALU_SIGNED_MPY_EN
    logic              q_q, q_d;
`endif

    logic              br_load, acc_clr, start, unused_cs;
    logic [2:0]        op;

    assign br_load   = bus.control_signal[CS_BR_LOAD];
    assign acc_clr   = bus.control_signal[CS_ACC_CLR];
    assign start     = bus.control_signal[CS_ALU_START];
    assign op        = bus.control_signal[CS_OP_LSB+2:CS_OP_LSB];
    assign unused_cs = ^bus.control_signal;

    logic [DATA_W:0]   sum_add, sum_sub;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;

    assign sum_add = {1'b0, acc_q} + {1'b0, br_q};
    assign sum_sub = {1'b0, acc_q} + {1'b0, ~br_q} + (DATA_W+1)'(1);

    // single-cycle ALU result and carry/overflow for the op field
    always_comb begin
        alu_res = acc_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'b000: begin
                alu_res = sum_add[DATA_W-1:0];
                alu_c   = sum_add[DATA_W];
                alu_v   = (acc_q[DATA_W-1] == br_q[DATA_W-1]) && (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
            end
            3'b001: begin
                alu_res = sum_sub[DATA_W-1:0];
                alu_c   = sum_sub[DATA_W];
                alu_v   = (acc_q[DATA_W-1] != br_q[DATA_W-1]) && (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
            end
            3'b010: alu_res = acc_q & br_q;
            3'b011: alu_res = acc_q | br_q;
            3'b100: alu_res = ~acc_q;
            3'b101: begin
                alu_res = {acc_q[DATA_W-2:0], 1'b0};
                alu_c   = acc_q[DATA_W-1];
            end
            3'b110: begin
                alu_res = {1'b0, acc_q[DATA_W-1:1]};
                alu_c   = acc_q[0];
            end
            default: alu_res = acc_q;
        endcase
    end

    logic [DATA_W-1:0] mul_mr, mul_acc;
    logic              mul_cv;

`ifdef ALU_SIGNED_MPY_EN
    logic [DATA_W-1:0] booth_t;
    logic              mul_q;

    // one Booth step: add/subtract M on a bit-pair transition, then arithmetic shift of {MR,ACC,q}
    always_comb begin
        booth_t = ({acc_q[0], q_q} == 2'b01) ? mr_q + m_q :
                  ({acc_q[0], q_q} == 2'b10) ? mr_q - m_q : mr_q;
        mul_mr  = {booth_t[DATA_W-1], booth_t[DATA_W-1:1]};
        mul_acc = {booth_t[0], acc_q[DATA_W-1:1]};
        mul_q   = acc_q[0];
        mul_cv  = mul_mr != {DATA_W{mul_acc[DATA_W-1]}};
    end
`else
    logic [DATA_W:0] mul_sum;

    // one unsigned shift-add step: conditionally add M into MR, then shift {carry,MR,ACC} right
    always_comb begin
        mul_sum = {1'b0, mr_q} + (acc_q[0] ? {1'b0, m_q} : '0);
        mul_mr  = mul_sum[DATA_W:1];
        mul_acc = {mul_sum[0], acc_q[DATA_W-1:1]};
        mul_cv  = |mul_mr;
    end
`endif

    // next-state logic: MUL iterates; IDLE and DONE accept clear, multiply start or a single-cycle op
    always_comb begin
        state_d = state_q;
        br_d    = br_load ? bus.data_from_mbr : br_q;
        acc_d   = acc_q;
        mr_d    = mr_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef ALU_SIGNED_MPY_EN
        q_d     = q_q;
`endif
        if (state_q == MUL) begin
            acc_d = mul_acc;
            mr_d  = mul_mr;
            cnt_d = cnt_q + CW'(1);
`ifdef ALU_SIGNED_MPY_EN
            q_d   = mul_q;
`endif
            if (cnt_q == CW'(DATA_W-1)) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                z_d     = ({mul_mr, mul_acc} == '0);
                n_d     = mul_mr[DATA_W-1];
                c_d     = mul_cv;
                v_d     = mul_cv;
            end
        end else begin
            state_d = IDLE;
            if (acc_clr) begin
                acc_d = '0;
                z_d   = 1'b1;
                n_d   = 1'b0;
                c_d   = 1'b0;
                v_d   = 1'b0;
            end else if (start && op == 3'b111) begin
                state_d = MUL;
                m_d     = br_q;
                mr_d    = '0;
                cnt_d   = '0;
                busy_d  = 1'b1;
`ifdef ALU_SIGNED_MPY_EN
                q_d     = 1'b0;
`endif
            end else if (start) begin
                acc_d = alu_res;
                z_d   = (alu_res == '0);
                n_d   = alu_res[DATA_W-1];
                c_d   = alu_c;
                v_d   = alu_v;
            end
        end
    end

    // state and datapath registers; reset aborts any multiply in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            br_q    <= '0;
            acc_q   <= '0;
            mr_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SIGNED_MPY_EN
            q_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
            acc_q   <= acc_d;
            mr_q    <= mr_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef ALU_SIGNED_MPY_EN
            q_q     <= q_d;
`endif
        end
    end

    assign bus.data_to_mbr_acc = acc_q;
    assign bus.data_to_mbr_mr  = mr_q;
    assign bus.flags           = {2'b00, done_q, busy_q, v_q, c_q, n_q, z_q};
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed table-driven bench for alu_acc; expectations follow ALU_SIGNED_MPY_EN
module tb_alu_acc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_acc_if bus ();

    alu_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] res;
        logic [3:0]  vcnz;
    } vec_t;

    vec_t vecs [11];

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
    localparam logic [2:0] NOT_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MPY = 3'b111;

    function automatic logic [31:0] cw(input logic bl, input logic clr, input logic st, input logic [2:0] op);
        cw        = '0;
        cw[10]    = bl;
        cw[11]    = clr;
        cw[12]    = st;
        cw[15:13] = op;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [31:0] c, input logic [15:0] d);
        @(negedge clk);
        bus.control_signal = c;
        bus.data_from_mbr  = d;
        @(posedge clk);
        #1;
        bus.control_signal = '0;
    endtask

    task automatic set_acc(input logic [15:0] v);
        step(cw(1, 0, 0, ADD), v);
        step(cw(0, 1, 0, ADD), 16'h0);
        step(cw(0, 0, 1, ADD), 16'h0);
    endtask

    task automatic run_mpy(input string nm, input logic [15:0] a, input logic [15:0] b, input logic restart,
                           input logic [15:0] e_mr, input logic [15:0] e_acc, input logic [3:0] e_vcnz);
        int busy_cnt;
        int done_cnt;
        set_acc(a);
        step(cw(1, 0, 0, ADD), b);
        step(cw(0, 0, 1, MPY), 16'h0);
        chk({nm, " busy after start"}, 32'(bus.busy), 32'd1);
        busy_cnt = 1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.control_signal = (restart && i == 3) ? cw(1, 0, 1, MPY) : '0;
            busy_cnt += int'(bus.busy);
            done_cnt += int'(bus.flags[5]);
        end
        chk({nm, " busy cycles"}, 32'(busy_cnt), 32'd16);
        chk({nm, " done pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, " product"}, {bus.data_to_mbr_mr, bus.data_to_mbr_acc}, {e_mr, e_acc});
        chk({nm, " flags"}, 32'(bus.flags), 32'(e_vcnz));
    endtask

    initial begin
        bus.control_signal = '0;
        bus.data_from_mbr  = '0;

        vecs[0]  = '{16'h0001, 16'h7FFF, ADD,  16'h8000, 4'b1010};
        vecs[1]  = '{16'h0005, 16'h0005, SUB,  16'h0000, 4'b0101};
        vecs[2]  = '{16'h8001, 16'h0000, SHL,  16'h0002, 4'b0100};
        vecs[3]  = '{16'h0003, 16'h0000, SHR,  16'h0001, 4'b0100};
        vecs[4]  = '{16'hF0F0, 16'h0FF0, AND_, 16'h00F0, 4'b0000};
        vecs[5]  = '{16'hF000, 16'h000F, OR_,  16'hF00F, 4'b0010};
        vecs[6]  = '{16'h00FF, 16'h1234, NOT_, 16'hFF00, 4'b0010};
        vecs[7]  = '{16'hFFFF, 16'h0001, ADD,  16'h0000, 4'b0101};
        vecs[8]  = '{16'h0003, 16'h0005, SUB,  16'hFFFE, 4'b0010};
        vecs[9]  = '{16'h8000, 16'h0001, SUB,  16'h7FFF, 4'b1100};
        vecs[10] = '{16'h8000, 16'h0000, SHR,  16'h4000, 4'b0000};

        repeat (3) @(posedge clk);
        #1;
        chk("reset acc", 32'(bus.data_to_mbr_acc), 32'h0);
        chk("reset mr", 32'(bus.data_to_mbr_mr), 32'h0);
        chk("reset flags", 32'(bus.flags), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(cw(0, 0, 1, ADD), 16'h0);
        chk("reset br zero", {bus.data_to_mbr_acc, 8'h0, bus.flags}, {16'h0, 8'h0, 8'h01});

        for (int i = 0; i < 11; i++) begin
            set_acc(vecs[i].a);
            step(cw(1, 0, 0, ADD), vecs[i].b);
            step(cw(0, 0, 1, vecs[i].op), 16'h0);
            chk($sformatf("vec%0d acc", i), 32'(bus.data_to_mbr_acc), 32'(vecs[i].res));
            chk($sformatf("vec%0d flags", i), 32'(bus.flags), 32'(vecs[i].vcnz));
            chk($sformatf("vec%0d mr", i), 32'(bus.data_to_mbr_mr), 32'h0);
        end

        run_mpy("mpy 3x2", 16'h0003, 16'h0002, 1'b0, 16'h0000, 16'h0006, 4'b0000);
        run_mpy("mpy 3x2 restart", 16'h0003, 16'h0002, 1'b1, 16'h0000, 16'h0006, 4'b0000);
`ifdef ALU_SIGNED_MPY_EN
        run_mpy("mpy ffff sq", 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 16'h0001, 4'b0000);
        run_mpy("mpy -3x2", 16'hFFFD, 16'h0002, 1'b0, 16'hFFFF, 16'hFFFA, 4'b0010);
`else
        run_mpy("mpy ffff sq", 16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'h0001, 4'b1110);
        run_mpy("mpy -3x2", 16'hFFFD, 16'h0002, 1'b0, 16'h0001, 16'hFFFA, 4'b1100);
`endif
        step(cw(0, 0, 1, ADD), 16'h0);
        chk("mr kept by add", 32'(bus.data_to_mbr_mr),
`ifdef ALU_SIGNED_MPY_EN
            32'hFFFF);
`else
            32'h0001);
`endif

        set_acc(16'h0005);
        step(cw(1, 0, 0, ADD), 16'h0003);
        step(cw(0, 1, 1, ADD), 16'h0);
        chk("clr beats start acc", 32'(bus.data_to_mbr_acc), 32'h0);
        chk("clr beats start flags", 32'(bus.flags), 32'h01);

        set_acc(16'h0001);
        step(cw(1, 0, 0, ADD), 16'h0001);
        step(cw(1, 0, 1, ADD), 16'h0009);
        chk("load+add old br", 32'(bus.data_to_mbr_acc), 32'h2);
        step(cw(0, 0, 1, ADD), 16'h0);
        chk("load+add new br", 32'(bus.data_to_mbr_acc), 32'hB);

        set_acc(16'hFFFF);
        step(cw(1, 0, 0, ADD), 16'hFFFF);
        step(cw(0, 0, 1, MPY), 16'h0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort busy", 32'(bus.busy), 32'h0);
        chk("abort product", {bus.data_to_mbr_mr, bus.data_to_mbr_acc}, 32'h0);
        chk("abort flags", 32'(bus.flags), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort stays idle", {bus.data_to_mbr_mr, bus.data_to_mbr_acc, 7'h0, bus.busy, bus.flags}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_acc.md
Name: alu_acc

Overview:
Datapath stage downstream of MBR. It latches operands from MBR into BR, runs ALU operations against ACC, and holds the high product word in MR. ACC and MR feed back into MBR's data_from_acc and data_from_mr inputs. Flags go to cu's flags input. Single-cycle ops finish in one edge; MPY is a 16-iteration shift-add sequence with a busy/done handshake.

Parameters:
DATA_W, 16, width of BR/ACC/MR (all arithmetic rules below are written for 16)
CS_BR_LOAD, 10, control_signal bit: BR <= data_from_mbr
CS_ACC_CLR, 11, control_signal bit: ACC <= 0
CS_ALU_START, 12, control_signal bit: execute op in OP field
CS_OP_LSB, 13, LSB of the 3-bit op field control_signal[CS_OP_LSB+2:CS_OP_LSB]

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
control_signal  input  32  control word from cu
data_from_mbr  input  16  operand from MBR
data_to_mbr_acc  output  16  ACC contents
data_to_mbr_mr  output  16  MR contents
flags  output  8  to cu: [0]Z [1]N [2]C [3]V [4]busy [5]done [7:6]=0
busy  output  1  MPY in progress (same as flags[4])

Behaviour:
- Reset (rst=0, asynchronous): BR, ACC, MR = 0; flags = 0; busy = 0; FSM = IDLE. Reset during MPY aborts it with no partial result kept.
- BR_LOAD: BR <= data_from_mbr on the edge. Allowed in any state.
- ACC_CLR (IDLE only): ACC <= 0; Z=1, N=C=V=0. Ignored while busy. ACC_CLR has priority over START in the same cycle, so START is dropped.
- START with BR_LOAD in the same cycle: the op uses the old BR value.
- Op codes, all single-cycle except MPY. ACC is updated on the sampling edge.
- 000 ADD: ACC <= ACC+BR. C = carry out. V = signed overflow.
- 001 SUB: ACC <= ACC+~BR+1. C = carry out (1 = no borrow). V = signed overflow.
- 010 AND, 011 OR: ACC <= ACC&BR / ACC|BR. C=V=0.
- 100 NOT: ACC <= ~ACC. C=V=0.
- 101 SHL: ACC <= ACC<<1. C = old ACC[15]. V=0.
- 110 SHR: logical shift right. C = old ACC[0]. V=0.
- 111 MPY: multi-cycle, see FSM.
- Z and N reflect the new ACC after every single-cycle op. MR is unchanged by single-cycle ops.
- FSM states: IDLE, MUL, DONE.
- IDLE + START(MPY) at edge E0: M <= BR (private copy), MR <= 0, ACC keeps the multiplier, cnt <= 0, busy <= 1, go to MUL.
- MUL, edges E1..E16, one iteration per edge: {c,sum} = MR + (ACC[0] ? M : 0), then {MR,ACC} <= {c,sum,ACC[15:1]}.
- On E16 (cnt=15): busy <= 0, done <= 1, flags updated, go to DONE.
- DONE: lasts one cycle; done returns to 0 at the next edge; go to IDLE. START is accepted in DONE as if in IDLE.
- MPY result is unsigned {MR,ACC}. Z = ({MR,ACC}==0), N = MR[15], C = V = (MR!=0).
- START received while in MUL is ignored; there is no queueing.
- busy is high for exactly 16 cycles (E0 to E16). done is high for exactly 1 cycle.
- cnt wraps only via the FSM; it is never observed outside.

Optional Feature:
ALU_SIGNED_MPY_EN
- Defined: MPY is two's-complement signed, radix-2 Booth. An extra bit q (reset 0) is appended below ACC.
  - Each of the 16 iterations: on {ACC[0],q}=01, MR += M; on 10, MR -= M; then arithmetic right shift of {MR,ACC,q}.
  - N = MR[15]. C = V = (MR != sign-extension of ACC[15]).
  - Latency is identical.
- Undefined: unsigned behaviour as above; q does not exist.

Test Plan:
1. Reset: hold rst=0 mid-run, then release → ACC=MR=BR=0, flags=8'h00, busy=0. Assert rst=0 at E8 of an MPY → busy=0 immediately, ACC=MR=0.
2. ADD: BR=16'h7FFF, ACC=16'h0001, ADD → ACC=16'h8000, N=1, V=1, C=0, Z=0. SUB: ACC=5, BR=5 → ACC=0, Z=1, C=1.
3. Shifts: ACC=16'h8001, SHL → ACC=16'h0002, C=1. SHR on 16'h0003 → 16'h0001, C=1.
4. MPY unsigned: ACC=16'h0003, BR=16'h0002, START at E0 → busy high 16 cycles, done pulses once, {MR,ACC}=32'h0000_0006, C=0. Repeat with ACC=BR=16'hFFFF → MR=16'hFFFE, ACC=16'h0001, C=V=1.
5. Simultaneous events: START(MPY) during MUL → ignored, result unchanged. ACC_CLR+START(ADD) in the same cycle → ACC=0, no add. BR_LOAD(9)+START(ADD) with old BR=1, ACC=1 → ACC=2, then BR=9.
6. ALU_SIGNED_MPY_EN defined: ACC=16'hFFFD (-3), BR=16'h0002 → {MR,ACC}=32'hFFFF_FFFA, N=1, C=V=0. Same stimulus undefined → 32'h0001_FFFA, C=V=1.
